// File: rtl/t01_memory_arbiter.sv
// Single-port memory arbiter: instruction fetch vs data access onto one shared bus.
// Optional T01_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed data priority.
module t01_memory_arbiter (
  input  logic        clk,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_width,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_sel,
  output logic [31:0] instr,
  output logic [31:0] data_o,
  output logic        ihit,
  output logic        dhit,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  state_t      r_state, w_next;

  logic        r_read, r_write;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_sel;
  logic        r_is_data, r_err;
  logic [1:0]  r_width, r_lane;
  logic [31:0] r_instr, r_data;

  logic        w_d_req, w_pick_d, w_grant_d, w_grant_i, w_misalign, w_xfer_done;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_rdata_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_d_req    = d_read | d_write;
  assign w_misalign = ((d_width == 2'd1) && d_addr[0]) ||
                      (d_width[1] && (d_addr[1:0] != 2'b00));

`ifdef T01_ARB_ROUND_ROBIN_EN
  logic r_last_data;

  // Under contention the side that did not win the last bus grant goes first.
  assign w_pick_d = w_d_req & (~i_req | ~r_last_data);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_last_data <= 1'b0;
    end else if (w_grant_d && !w_misalign) begin
      r_last_data <= 1'b1;
    end else if (w_grant_i) begin
      r_last_data <= 1'b0;
    end
  end
`else
  assign w_pick_d = w_d_req;
`endif

  assign w_grant_d   = (r_state == IDLE) & w_pick_d;
  assign w_grant_i   = (r_state == IDLE) & i_req & ~w_pick_d;
  assign w_xfer_done = ((r_state == IBUS) || (r_state == DBUS)) & m_ack;

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = '0;
    if (!d_read) begin
      w_wdata = d_wdata;
      case (d_width)
        2'd0: begin
          w_sel   = 4'b0001 << d_addr[1:0];
          w_wdata = {4{d_wdata[7:0]}};
        end
        2'd1: begin
          w_sel   = 4'b0011 << {d_addr[1], 1'b0};
          w_wdata = {2{d_wdata[15:0]}};
        end
        default: w_sel = 4'b1111;
      endcase
    end
  end

  assign w_byte = m_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    case (r_width)
      2'd0:    w_rdata_ext = {{24{w_byte[7]}}, w_byte};
      2'd1:    w_rdata_ext = {{16{w_half[15]}}, w_half};
      default: w_rdata_ext = m_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ihit   = 1'b0;
    dhit   = 1'b0;
    err    = 1'b0;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grant_d && w_misalign) w_next = RESP;
        else if (w_grant_d)          w_next = DBUS;
        else if (w_grant_i)          w_next = IBUS;
      end
      IBUS, DBUS: begin
        if (m_ack) w_next = RESP;
      end
      RESP: begin
        ihit   = ~r_is_data;
        dhit   = r_is_data;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus fields are loaded only at grant; a misaligned trap leaves them untouched.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_is_data <= 1'b0;
      r_err     <= 1'b0;
      r_width   <= '0;
      r_lane    <= '0;
      r_instr   <= '0;
      r_data    <= '0;
    end else if (w_grant_i) begin
      r_read    <= 1'b1;
      r_write   <= 1'b0;
      r_addr    <= i_addr & 32'hFFFF_FFFC;
      r_wdata   <= '0;
      r_sel     <= 4'b1111;
      r_is_data <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_grant_d) begin
      r_is_data <= 1'b1;
      r_err     <= w_misalign;
      r_width   <= d_width;
      r_lane    <= d_addr[1:0];
      if (w_misalign) begin
        r_data <= '0;
      end else begin
        r_read  <= d_read;
        r_write <= ~d_read;
        r_addr  <= d_addr & 32'hFFFF_FFFC;
        r_wdata <= w_wdata;
        r_sel   <= w_sel;
      end
    end else if (w_xfer_done) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      if (r_read) begin
        if (r_is_data) r_data  <= w_rdata_ext;
        else           r_instr <= m_rdata;
      end
    end
  end

  assign m_read  = r_read;
  assign m_write = r_write;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_sel   = r_sel;
  assign instr   = r_instr;
  assign data_o  = r_data;

endmodule
